// File: rtl/alu_word_sequencer.sv
// Word-wide ALU sequencer: drives one W-bit combinational slice over N cycles,
// chaining carry/shift bits and returning the word result with flags.
package definitions;
  typedef enum logic [2:0] {ADD = 3'd0, LSH = 3'd1, BSH = 3'd2, XOR = 3'd3, AND = 3'd4} op_mne;
endpackage

// state | meaning
// IDLE  | waiting for a request
// EXEC  | slice i issued with the request opcode
// FIX   | slice ADD had an incoming carry; add 1 to the stored partial sum
// RESP  | word response presented until taken
module alu_word_sequencer #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [W*N-1:0]   req_a,
  input  logic [W*N-1:0]   req_b,
  input  logic             req_cin,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_sc_in,
  input  logic [W-1:0]     alu_out,
  input  logic             alu_sc_out,
  input  logic             alu_zero,
  input  logic             alu_pf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W*N-1:0]   rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_parity
);
  import definitions::*;

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]     state;
  logic [IW-1:0]  idx;
  logic [2:0]     op_r;
  logic [W*N-1:0] a_r, b_r, result;
  logic [W-1:0]   sum;
  logic           c, c1, zacc, pacc;

  logic           fin, last, fix_needed, carry_op;
  logic           c_next, zacc_next, pacc_next;
  logic [W*N-1:0] res_next;

  assign req_ready  = (state == S_IDLE);
  assign rsp_valid  = (state == S_RESP);
  assign last       = (idx == IW'(N - 1));
  assign fix_needed = (op_r == ADD) && c;
  assign carry_op   = (op_r == ADD) || (op_r == LSH) || (op_r == BSH);

  // Slice drive is decoded from registered state only.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    alu_sc_in = 1'b0;
    case (state)
      S_EXEC: begin
        alu_a     = a_r[idx*W +: W];
        alu_b     = b_r[idx*W +: W];
        alu_op    = (op_r == BSH) ? LSH : op_r;
        alu_sc_in = c;
      end
      S_FIX: begin
        alu_a  = sum;
        alu_b  = W'(1);
        alu_op = ADD;
      end
      default: ;
    endcase
  end

  always_comb begin
    fin       = 1'b0;
    c_next    = c;
    res_next  = result;
    res_next[idx*W +: W] = alu_out;
    zacc_next = zacc & alu_zero;
    pacc_next = pacc ^ alu_pf;
    if (state == S_EXEC && !fix_needed) begin
      fin    = 1'b1;
      c_next = carry_op ? alu_sc_out : 1'b0;
    end else if (state == S_FIX) begin
      fin    = 1'b1;
      c_next = c1 | alu_sc_out;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      result     <= '0;
      sum        <= '0;
      c          <= 1'b0;
      c1         <= 1'b0;
      zacc       <= 1'b0;
      pacc       <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_parity <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op_r  <= req_op;
          a_r   <= req_a;
          b_r   <= req_b;
          idx   <= '0;
          zacc  <= 1'b1;
          pacc  <= 1'b0;
          state <= S_EXEC;
          case (req_op)
            ADD, LSH: c <= req_cin;
            BSH:      c <= req_a[W*N-1];
            default:  c <= 1'b0;
          endcase
        end
        S_EXEC: if (fix_needed) begin
          sum   <= alu_out;
          c1    <= alu_sc_out;
          state <= S_FIX;
        end
        S_FIX: ;
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (fin) begin
        result <= res_next;
        zacc   <= zacc_next;
        pacc   <= pacc_next;
        c      <= c_next;
        if (last) begin
          state      <= S_RESP;
          rsp_result <= res_next;
          rsp_carry  <= c_next;
          rsp_zero   <= zacc_next;
          rsp_parity <= pacc_next;
        end else begin
          idx   <= idx + IW'(1);
          state <= S_EXEC;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_word_sequencer.sv
// Bench for alu_word_sequencer: behavioural 8-bit slice plus a word-level
// reference model for result, flags and latency.
module tb_alu_word_sequencer;
  import definitions::*;

  localparam int W = 8;
  localparam int N = 2;
  localparam int WN = W * N;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [WN-1:0] req_a = '0, req_b = '0;
  logic          req_cin = 1'b0;
  logic [W-1:0]  alu_a, alu_b, alu_out;
  logic [2:0]    alu_op;
  logic          alu_sc_in, alu_sc_out, alu_zero, alu_pf;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [WN-1:0] rsp_result;
  logic          rsp_carry, rsp_zero, rsp_parity;

  int tests = 0;
  int fails = 0;
  logic [2:0] tr_op [0:15];
  logic       tr_sc [0:15];

  alu_word_sequencer #(.W(W), .N(N)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sc_in(alu_sc_in),
    .alu_out(alu_out), .alu_sc_out(alu_sc_out), .alu_zero(alu_zero), .alu_pf(alu_pf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_parity(rsp_parity)
  );

  always #5 Clk = ~Clk;

  // External slice: ADD has no carry-in; unlisted codes return a|b.
  always_comb begin
    alu_out    = '0;
    alu_sc_out = 1'b0;
    case (alu_op)
      ADD:      {alu_sc_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      LSH, BSH: begin alu_out = {alu_a[W-2:0], alu_sc_in}; alu_sc_out = alu_a[W-1]; end
      XOR:      alu_out = alu_a ^ alu_b;
      AND:      alu_out = alu_a & alu_b;
      default:  alu_out = alu_a | alu_b;
    endcase
  end
  assign alu_zero = (alu_out == '0);
  assign alu_pf   = ^alu_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word-level reference; fix count = number of slices whose incoming carry is 1.
  function automatic void ref_word(input logic [2:0] op, input logic [WN-1:0] a, b,
                                   input logic cin, output logic [WN-1:0] res,
                                   output logic cy, output int fx);
    longint s, m;
    fx = 0;
    cy = 1'b0;
    case (op)
      ADD: begin
        s   = longint'(a) + longint'(b) + longint'(cin);
        res = s[WN-1:0];
        cy  = s[WN];
        for (int i = 0; i < N; i++) begin
          m  = longint'(1) << (W * i);
          fx += int'(((longint'(a) % m) + (longint'(b) % m) + longint'(cin)) >> (W * i));
        end
      end
      LSH: begin res = {a[WN-2:0], cin};       cy = a[WN-1]; end
      BSH: begin res = {a[WN-2:0], a[WN-1]};   cy = a[WN-1]; end
      XOR: res = a ^ b;
      AND: res = a & b;
      default: res = a | b;
    endcase
  endfunction

  // Called just after a negedge; returns just after a negedge in IDLE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [WN-1:0] a, b,
                        input logic cin, input int hold, input bit chain,
                        input logic [2:0] nop, input logic [WN-1:0] na, nb, input logic ncin);
    logic [WN-1:0] er;
    logic ec;
    int ef, w, lat;
    ref_word(op, a, b, cin, er, ec, ef);
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge Clk); w++; end
    chk({tag, "_accept_timeout"}, 32'(w < 20), 32'd1);
    @(posedge Clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge Clk);
      lat++;
      if (lat < 16) begin tr_op[lat] = alu_op; tr_sc[lat] = alu_sc_in; end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(N + ef + 1));
    chk({tag, "_result"}, 32'(rsp_result), 32'(er));
    chk({tag, "_carry"},  32'(rsp_carry),  32'(ec));
    chk({tag, "_zero"},   32'(rsp_zero),   32'(er == '0));
    chk({tag, "_parity"}, 32'(rsp_parity), 32'(^er));
    for (int k = 0; k < hold; k++) begin
      @(negedge Clk);
      chk({tag, "_hold_valid"},  32'(rsp_valid),  32'd1);
      chk({tag, "_hold_result"}, 32'(rsp_result), 32'(er));
      chk({tag, "_hold_zero"},   32'(rsp_zero),   32'(er == '0));
    end
    rsp_ready = 1'b1;
    if (chain) begin
      req_op = nop; req_a = na; req_b = nb; req_cin = ncin; req_valid = 1'b1;
    end
    @(posedge Clk);
    @(negedge Clk);
    rsp_ready = 1'b0;
    chk({tag, "_post_valid"},  32'(rsp_valid),  32'd0);
    chk({tag, "_post_ready"},  32'(req_ready),  32'd1);
    chk({tag, "_post_result"}, 32'(rsp_result), 32'(er));
    chk({tag, "_post_aluop"},  32'(alu_op),     32'd0);
  endtask

  initial begin
    logic [2:0] rop;
    logic [WN-1:0] ra, rb;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_alu_op",     32'(alu_op),     32'd0);
    chk("rst_alu_a",      32'(alu_a),      32'd0);
    chk("rst_flags",      32'({rsp_carry, rsp_zero, rsp_parity}), 32'd0);

    run_op("add_fix1", ADD, 16'h00FF, 16'h0001, 1'b0, 0, 1'b0, '0, '0, '0, 1'b0);
    run_op("add_fix2", ADD, 16'hFFFF, 16'h0000, 1'b1, 0, 1'b0, '0, '0, '0, 1'b0);

    run_op("bsh", BSH, 16'h8001, 16'h0000, 1'b0, 0, 1'b0, '0, '0, '0, 1'b0);
    chk("bsh_op_s0", 32'(tr_op[1]), 32'(LSH));
    chk("bsh_op_s1", 32'(tr_op[2]), 32'(LSH));
    chk("bsh_sc_s0", 32'(tr_sc[1]), 32'd1);
    chk("bsh_sc_s1", 32'(tr_sc[2]), 32'd0);

    run_op("xor_bp", XOR, 16'h1234, 16'h1234, 1'b0, 3, 1'b1, AND, 16'hF0F0, 16'h3C3C, 1'b0);
    run_op("and_chain", AND, 16'hF0F0, 16'h3C3C, 1'b0, 0, 1'b0, '0, '0, '0, 1'b0);

    // Reset while slice 0 is in its fix-up cycle.
    req_op = ADD; req_a = 16'hFFFF; req_b = 16'h0000; req_cin = 1'b1; req_valid = 1'b1;
    @(posedge Clk);
    #1 req_valid = 1'b0;
    @(negedge Clk);
    chk("rmid_exec_op", 32'(alu_op),    32'(ADD));
    chk("rmid_exec_sc", 32'(alu_sc_in), 32'd1);
    @(negedge Clk);
    chk("rmid_fix_a", 32'(alu_a), 32'hFF);
    chk("rmid_fix_b", 32'(alu_b), 32'h01);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk("rmid_ready",  32'(req_ready), 32'd1);
    chk("rmid_alu_op", 32'(alu_op),    32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("rmid_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge Clk);
    end
    run_op("after_rst", ADD, 16'hFFFF, 16'h0000, 1'b1, 1, 1'b0, '0, '0, '0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra = '1;
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 2));
      run_op($sformatf("rnd%0d", t), rop, ra, rb, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'b0, '0, '0, '0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
